dir_ctrl: RTL and testbench

DIR_CTRL -- requirements
Module: dir_ctrl

---
 rtl/dir_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_dir_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dir_ctrl.sv
// Two-processor directory controller: 4-entry directory with data, one request in flight.
// Latency: gnt->rsp_valid is 2 cycles without coherence/memory traffic; otherwise waits on coh_ack/mem_ack.
// Backpressure: requests wait outside IDLE; coh/mem requests are held until acked. Option: DIR_CTRL_RR_ARB_EN.
module dir_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [1:0]        p0_op,
  input  logic [2:0]        p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic [1:0]        p1_op,
  input  logic [2:0]        p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              rsp_valid,
  output logic              rsp_dst,
  output logic [DATA_W-1:0] rsp_data,
  output logic              coh_valid,
  output logic              coh_dst,
  output logic [1:0]        coh_type,
  output logic [2:0]        coh_addr,
  input  logic              coh_ack,
  input  logic [DATA_W-1:0] coh_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_DI = 2'b00, ST_DS = 2'b01, ST_DM = 2'b10;
  localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_WB = 2'b10;
  localparam logic [1:0] C_INV = 2'b00, C_FETCH = 2'b01, C_FETCH_INV = 2'b10;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT_COH, EVICT_WB, FILL, COH_WAIT, RESP} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] dir_data [4];
  logic [2:0]        dir_tag  [4];
  logic [1:0]        dir_st   [4];
  logic [1:0]        dir_sh   [4];

  logic              live;      // low during reset and the cycle after it
  logic [1:0]        op_q;
  logic [2:0]        addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              id_q;
  logic [1:0]        pend;      // coherence targets still to be serviced (bit1=P0, bit0=P1)
  logic [1:0]        ctype;
  logic [DATA_W-1:0] wb_data;   // dirty data fetched from the owner during eviction
  logic              filled;    // entry was just refilled, so a DI entry with matching tag counts as a hit

  logic              out_en, pick1, hit;
  logic [1:0]        idx, rb, own_mask, others, cur_bit, pend_left, lk_pend, lk_type, sel_op;
  logic [2:0]        e_tag;
  logic [1:0]        e_st, e_sh;
  logic [DATA_W-1:0] e_data;

  assign out_en    = live && !reset;
  assign idx       = addr_q[1:0];
  assign e_tag     = dir_tag[idx];
  assign e_st      = dir_st[idx];
  assign e_sh      = dir_sh[idx];
  assign e_data    = dir_data[idx];
  assign hit       = (e_tag == addr_q) && ((e_st != ST_DI) || filled);
  assign rb        = id_q ? 2'b01 : 2'b10;
  assign own_mask  = e_sh[1] ? 2'b10 : 2'b01;
  assign others    = e_sh & ~rb;
  assign cur_bit   = pend[1] ? 2'b10 : 2'b01;
  assign pend_left = pend & ~cur_bit;
  assign sel_op    = p1_gnt ? p1_op : p0_op;

`ifdef DIR_CTRL_RR_ARB_EN
  logic prio;  // 0: P0 wins a tie, 1: P1 wins a tie
  assign pick1 = p1_req && (!p0_req || prio);

  // Round-robin pointer: the port just granted loses the next tie.
  always_ff @(posedge clock) begin
    if (reset)                 prio <= 1'b0;
    else if (p0_gnt || p1_gnt) prio <= p0_gnt;
  end
`else
  assign pick1 = p1_req && !p0_req;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state, outputs and the coherence plan chosen at lookup.
  always_comb begin
    state_nx = state;
    p0_gnt = 1'b0; p1_gnt = 1'b0;
    rsp_valid = 1'b0; rsp_dst = 1'b0; rsp_data = '0;
    coh_valid = 1'b0; coh_dst = 1'b0; coh_type = 2'b00; coh_addr = 3'b000;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 3'b000; mem_wdata = '0;
    lk_pend = 2'b00; lk_type = C_INV;
    case (state)
      IDLE: if (out_en && (p0_req || p1_req)) begin
        p1_gnt = pick1; p0_gnt = !pick1; state_nx = LOOKUP;
      end
      LOOKUP: begin
        state_nx = RESP;
        if (!hit) begin
          if (op_q == OP_WB) state_nx = RESP;
          else if (e_st == ST_DS && e_sh != 2'b00) begin
            lk_pend = e_sh; lk_type = C_INV; state_nx = EVICT_COH;
          end else if (e_st == ST_DM) begin
            lk_pend = own_mask; lk_type = C_FETCH_INV; state_nx = EVICT_COH;
          end else state_nx = FILL;
        end else if (op_q == OP_WR) begin
          if (e_st == ST_DS && others != 2'b00) begin
            lk_pend = others; lk_type = C_INV; state_nx = COH_WAIT;
          end else if (e_st == ST_DM && e_sh != rb) begin
            lk_pend = own_mask; lk_type = C_FETCH_INV; state_nx = COH_WAIT;
          end
        end else if (op_q == OP_RD && e_st == ST_DM && e_sh != rb) begin
          lk_pend = own_mask; lk_type = C_FETCH; state_nx = COH_WAIT;
        end
      end
      EVICT_COH, COH_WAIT: begin
        coh_valid = 1'b1; coh_dst = !pend[1]; coh_type = ctype; coh_addr = e_tag;
        if (coh_ack && pend_left == 2'b00) begin
          if (state == COH_WAIT)         state_nx = RESP;
          else if (ctype == C_FETCH_INV) state_nx = EVICT_WB;
          else                           state_nx = FILL;
        end
      end
      EVICT_WB: begin
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = e_tag; mem_wdata = wb_data;
        if (mem_ack) state_nx = FILL;
      end
      FILL: begin
        mem_req = 1'b1; mem_addr = addr_q;
        if (mem_ack) state_nx = LOOKUP;
      end
      RESP: begin
        rsp_valid = 1'b1; rsp_dst = id_q; rsp_data = e_data; state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!out_en) begin
      p0_gnt = 1'b0; p1_gnt = 1'b0;
      rsp_valid = 1'b0; rsp_dst = 1'b0; rsp_data = '0;
      coh_valid = 1'b0; coh_dst = 1'b0; coh_type = 2'b00; coh_addr = 3'b000;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = 3'b000; mem_wdata = '0;
    end
  end

  // Request latch and coherence bookkeeping for the transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      live <= 1'b0; op_q <= OP_RD; addr_q <= 3'b000; wdata_q <= '0; id_q <= 1'b0;
      pend <= 2'b00; ctype <= C_INV; wb_data <= '0; filled <= 1'b0;
    end else begin
      live <= 1'b1;
      if (p0_gnt || p1_gnt) begin
        id_q    <= p1_gnt;
        op_q    <= (sel_op == 2'b11) ? OP_RD : sel_op;
        addr_q  <= p1_gnt ? p1_addr : p0_addr;
        wdata_q <= p1_gnt ? p1_wdata : p0_wdata;
        filled  <= 1'b0;
      end
      if (state == LOOKUP) begin
        pend <= lk_pend; ctype <= lk_type;
      end
      if ((state == EVICT_COH || state == COH_WAIT) && coh_ack) begin
        pend <= pend_left;
        if (state == EVICT_COH) wb_data <= coh_data;
      end
      if (state == FILL && mem_ack) filled <= 1'b1;
    end
  end

  // Directory entry updates: immediate hits, coherence completion and refill.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        dir_data[i] <= '0; dir_tag[i] <= 3'b000; dir_st[i] <= ST_DI; dir_sh[i] <= 2'b00;
      end
    end else begin
      case (state)
        LOOKUP: if (hit && state_nx == RESP) begin
          case (op_q)
            OP_WR: if (e_st != ST_DM) begin
              dir_st[idx] <= ST_DM; dir_sh[idx] <= rb;
            end
            OP_WB: if (e_st == ST_DM && e_sh == rb) begin
              dir_data[idx] <= wdata_q; dir_st[idx] <= ST_DI; dir_sh[idx] <= 2'b00;
            end
            default: begin
              if (e_st == ST_DI) begin
                dir_st[idx] <= ST_DS; dir_sh[idx] <= rb;
              end else if (e_st == ST_DS) dir_sh[idx] <= e_sh | rb;
            end
          endcase
        end
        COH_WAIT: if (coh_ack && pend_left == 2'b00) begin
          case (ctype)
            C_FETCH: begin
              dir_data[idx] <= coh_data; dir_st[idx] <= ST_DS; dir_sh[idx] <= 2'b11;
            end
            C_FETCH_INV: begin
              dir_data[idx] <= coh_data; dir_st[idx] <= ST_DM; dir_sh[idx] <= rb;
            end
            default: begin
              dir_st[idx] <= ST_DM; dir_sh[idx] <= rb;
            end
          endcase
        end
        FILL: if (mem_ack) begin
          dir_data[idx] <= mem_rdata; dir_tag[idx] <= addr_q;
          dir_st[idx] <= ST_DI; dir_sh[idx] <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dir_ctrl.sv
// Testbench for dir_ctrl: acts as both processors, the peer caches and memory.
// Expected coherence/memory traffic and replies come from a transaction-level directory model.
module tb_dir_ctrl;
  localparam int DW = 16;

  logic clock = 1'b0, reset = 1'b1;
  logic p0_req = 0, p1_req = 0;
  logic [1:0] p0_op = 0, p1_op = 0;
  logic [2:0] p0_addr = 0, p1_addr = 0;
  logic [DW-1:0] p0_wdata = 0, p1_wdata = 0;
  logic p0_gnt, p1_gnt, rsp_valid, rsp_dst, coh_valid, coh_dst, mem_req, mem_we;
  logic [DW-1:0] rsp_data, mem_wdata;
  logic [1:0] coh_type;
  logic [2:0] coh_addr, mem_addr;
  logic coh_ack = 0, mem_ack = 0;
  logic [DW-1:0] coh_data = 0, mem_rdata = 0;

  dir_ctrl #(.DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_op(p0_op), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_op(p1_op), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .rsp_valid(rsp_valid), .rsp_dst(rsp_dst), .rsp_data(rsp_data),
    .coh_valid(coh_valid), .coh_dst(coh_dst), .coh_type(coh_type), .coh_addr(coh_addr),
    .coh_ack(coh_ack), .coh_data(coh_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Directory model: states 0=DI 1=DS 2=DM, sharer bit1=P0 bit0=P1.
  logic [DW-1:0] m_data [4];
  logic [2:0]    m_tag  [4];
  logic [1:0]    m_st   [4];
  logic [1:0]    m_sh   [4];

  typedef struct {
    bit            is_mem;
    bit            dst_we;
    logic [1:0]    typ;
    logic [2:0]    addr;
    logic [DW-1:0] wd;
  } ev_t;
  ev_t exp_q[$];

  task automatic push_coh(input bit dst, input logic [1:0] t, input logic [2:0] a);
    ev_t e;
    e.is_mem = 0; e.dst_we = dst; e.typ = t; e.addr = a; e.wd = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_mem(input bit we, input logic [2:0] a, input logic [DW-1:0] wd);
    ev_t e;
    e.is_mem = 1; e.dst_we = we; e.typ = 2'b00; e.addr = a; e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_data[i] = '0; m_tag[i] = 3'b000; m_st[i] = 2'd0; m_sh[i] = 2'b00;
    end
  endtask

  // One whole transaction: queues the traffic the directory must issue, returns the reply data.
  task automatic model(input bit r, input logic [1:0] op_in, input logic [2:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] cv, input logic [DW-1:0] mv,
                       output logic [DW-1:0] rsp);
    int i;
    logic [1:0] op, me, oth;
    bit owner;
    i   = int'(a[1:0]);
    op  = (op_in == 2'd3) ? 2'd0 : op_in;
    me  = r ? 2'b01 : 2'b10;
    if (!(m_tag[i] == a && m_st[i] != 2'd0)) begin
      if (op == 2'd2) begin
        rsp = m_data[i];
        return;
      end
      if (m_st[i] == 2'd1) begin
        if (m_sh[i][1]) push_coh(0, 2'd0, m_tag[i]);
        if (m_sh[i][0]) push_coh(1, 2'd0, m_tag[i]);
      end else if (m_st[i] == 2'd2) begin
        push_coh(!m_sh[i][1], 2'd2, m_tag[i]);
        push_mem(1, m_tag[i], cv);
      end
      push_mem(0, a, '0);
      m_data[i] = mv; m_tag[i] = a; m_st[i] = 2'd0; m_sh[i] = 2'b00;
    end
    owner = !m_sh[i][1];
    oth   = m_sh[i] & ~me;
    case (op)
      2'd0: begin
        if (m_st[i] == 2'd0) begin m_st[i] = 2'd1; m_sh[i] = me; end
        else if (m_st[i] == 2'd1) m_sh[i] = m_sh[i] | me;
        else if (m_sh[i] != me) begin
          push_coh(owner, 2'd1, a);
          m_data[i] = cv; m_st[i] = 2'd1; m_sh[i] = 2'b11;
        end
      end
      2'd1: begin
        if (m_st[i] == 2'd1) begin
          if (oth[1]) push_coh(0, 2'd0, a);
          if (oth[0]) push_coh(1, 2'd0, a);
        end else if (m_st[i] == 2'd2 && m_sh[i] != me) begin
          push_coh(owner, 2'd2, a);
          m_data[i] = cv;
        end
        m_st[i] = 2'd2; m_sh[i] = me;
      end
      default: begin
        if (m_st[i] == 2'd2 && m_sh[i] == me) begin
          m_data[i] = wd; m_st[i] = 2'd0; m_sh[i] = 2'b00;
        end
      end
    endcase
    rsp = m_data[i];
  endtask

  function automatic logic [63:0] outs_vec();
    return {16'h0, p0_gnt, p1_gnt, rsp_valid, rsp_dst, rsp_data, coh_valid, coh_dst, coh_type,
            coh_addr, mem_req, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic do_reset();
    reset = 1; p0_req = 0; p1_req = 0; coh_ack = 0; mem_ack = 0;
    repeat (2) begin
      @(negedge clock);
      check("out_in_reset", outs_vec(), 64'h0);
    end
    @(posedge clock); #1;
    reset = 0; p0_req = 1; p0_op = 2'd2; p0_addr = 3'd0;
    @(negedge clock);
    check("out_after_reset", outs_vec(), 64'h0);
    @(posedge clock); #1;
    p0_req = 0;
    model_reset();
  endtask

  task automatic do_req(input bit r, input logic [1:0] op, input logic [2:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] cv, input logic [DW-1:0] mv);
    logic [DW-1:0] exp_rsp;
    bit granted, done, no_ev;
    int gcyc;
    ev_t e;
    granted = 0; done = 0; gcyc = 0;
    exp_q.delete();
    model(r, op, a, wd, cv, mv, exp_rsp);
    no_ev = (exp_q.size() == 0);
    coh_data = cv; mem_rdata = mv;
    @(posedge clock); #1;
    if (r) begin p1_req = 1; p1_op = op; p1_addr = a; p1_wdata = wd; end
    else   begin p0_req = 1; p0_op = op; p0_addr = a; p0_wdata = wd; end
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clock);
      if (granted) check("gnt_busy", {p0_gnt, p1_gnt}, 2'b00);
      else if (p0_gnt || p1_gnt) begin
        check("gnt_port", {p0_gnt, p1_gnt}, r ? 2'b01 : 2'b10);
        granted = 1; gcyc = cyc;
      end
      if (coh_valid || mem_req) begin
        if (exp_q.size() == 0) check("unexp_req", {coh_valid, mem_req}, 2'b00);
        else begin
          e = exp_q[0];
          check("req_kind", {coh_valid, mem_req}, e.is_mem ? 2'b01 : 2'b10);
          if (e.is_mem) begin
            check("mem_we", mem_we, e.dst_we);
            check("mem_addr", mem_addr, e.addr);
            if (e.dst_we) check("mem_wdata", mem_wdata, e.wd);
          end else begin
            check("coh_dst", coh_dst, e.dst_we);
            check("coh_type", coh_type, e.typ);
            check("coh_addr", coh_addr, e.addr);
          end
          if ($urandom_range(1, 0) == 1) begin
            if (coh_valid) coh_ack = 1; else mem_ack = 1;
            void'(exp_q.pop_front());
          end
        end
      end else if ($urandom_range(3, 0) == 0) begin
        coh_ack = 1; mem_ack = 1;  // stray acks must be ignored
      end
      if (rsp_valid) begin
        check("rsp_dst", rsp_dst, r);
        check("rsp_data", rsp_data, exp_rsp);
        check("events_left", exp_q.size(), 0);
        if (no_ev) check("latency", cyc - gcyc, 2);
        done = 1;
      end
      @(posedge clock); #1;
      coh_ack = 0; mem_ack = 0;
      if (granted) begin p0_req = 0; p1_req = 0; end
    end
    if (!done) check("rsp_timeout", 0, 1);
  endtask

  task automatic arb_test();
    bit exp_w [3];
    int left0, left1, gi;
    left0 = 2; left1 = 1; gi = 0;
`ifdef DIR_CTRL_RR_ARB_EN
    exp_w = '{1'b0, 1'b1, 1'b0};
`else
    exp_w = '{1'b0, 1'b0, 1'b1};
`endif
    @(posedge clock); #1;
    p0_req = 1; p0_op = 2'd2; p0_addr = 3'd3; p0_wdata = 16'h1234;
    p1_req = 1; p1_op = 2'd2; p1_addr = 3'd4; p1_wdata = 16'h5678;
    for (int cyc = 0; cyc < 60 && gi < 3; cyc++) begin
      @(negedge clock);
      if (p0_gnt || p1_gnt) begin
        check("arb_winner", p1_gnt, exp_w[gi]);
        check("arb_single", p0_gnt & p1_gnt, 0);
        if (p1_gnt) left1--; else left0--;
        gi++;
      end
      if (rsp_valid) check("arb_rsp_data", rsp_data, 16'h0);
      @(posedge clock); #1;
      p0_req = (left0 > 0); p1_req = (left1 > 0);
    end
    check("arb_grants", gi, 3);
    repeat (4) @(posedge clock);
    #1;
  endtask

  logic [2:0] mid_a;

  initial begin
    do_reset();
    // Directed walk: read fill, upgrade with invalidate, fetch from owner, dirty eviction.
    do_req(0, 2'd0, 3'd0, 16'h0, 16'h0000, 16'h000A);
    do_req(1, 2'd1, 3'd0, 16'h0, 16'h0000, 16'h0BAD);
    do_req(0, 2'd0, 3'd0, 16'h0, 16'h0044, 16'h0BAD);
    do_req(1, 2'd1, 3'd2, 16'h0, 16'h0011, 16'h0022);
    do_req(0, 2'd0, 3'd6, 16'h0, 16'h0033, 16'h0066);
    for (int k = 0; k < 300; k++)
      do_req(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)),
             16'($urandom), 16'($urandom), 16'($urandom));
    // Reset in the middle of a transaction that must refill.
    mid_a = {~m_tag[1][2], 2'b01};
    @(posedge clock); #1;
    p0_req = 1; p0_op = 2'd1; p0_addr = mid_a;
    @(negedge clock);
    check("midop_gnt", p0_gnt, 1);
    @(posedge clock); #1;
    p0_req = 0;
    for (int c = 0; c < 10 && !(coh_valid || mem_req); c++) @(negedge clock);
    check("midop_busy", coh_valid | mem_req, 1);
    do_reset();
    for (int k = 0; k < 60; k++)
      do_req(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)),
             16'($urandom), 16'($urandom), 16'($urandom));
    do_reset();
    arb_test();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
